pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID and ID/EX pipeline registers of the 16-bit 5-stage core.
//  Keeps its own scoreboard of in-flight destination registers (EX, MEM, WB).
//  Stalls on RAW hazards, flushes on taken branches/jumps, drains the pipe on HALT.
//  Drives the PC and IF/ID enables and the ID/EX bubble (zeroes all ID/EX control bits).
// PARAMETERS
//  REG_BITS     3  register-specifier width
//  WB_BYPASS    1  1 = regfile writes before it reads, so the WB-stage writer is not a hazard
//  DRAIN_CYCLES 4  cycles in DRAIN, until HALT has retired from WB
//  CNT_W        16 width of the stall performance counter
// PORTS
//  clk             in  1        core clock; all state updates on the rising edge
//  rst             in  1        asynchronous reset, active-low
//  id_valid        in  1        a real instruction is in ID
//  id_rs_used      in  1        the ID instruction reads rs
//  id_rs           in  REG_BITS rs specifier
//  id_rt_used      in  1        the ID instruction reads rt
//  id_rt           in  REG_BITS rt specifier
//  id_reg_wrt      in  1        the ID instruction writes a register
//  id_write_reg    in  REG_BITS destination of the ID instruction
//  id_halt         in  1        the ID instruction is HALT
//  ex_redirect     in  1        branch taken, or jump resolved, in EX this cycle
//  pc_en           out 1        PC may update
//  if_id_en        out 1        IF/ID register may load
//  if_id_flush     out 1        IF/ID loads a NOP
//  id_ex_bubble    out 1        ID/EX loads all-zero control (bubble)
//  halted          out 1        pipe drained after HALT
//  stall_cnt       out CNT_W    count of RAW-stall cycles, saturating
// BEHAVIOUR
//  Reset (rst=0, async):
//   - State RUN; scoreboard entries invalid; stall_cnt=0; drain counter 0.
//   - Outputs held at pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, halted=0.
//   - Released state after reset: RUN with outputs 1,1,0,0,0.
//  Scoreboard: sb_ex, sb_mem, sb_wb, each {v, reg}; shifts every cycle (never stalls).
//   - sb_ex <= issue & id_reg_wrt ? {1, id_write_reg} : {0, x}.
//   - sb_mem <= sb_ex; sb_wb <= sb_mem.
//   - issue = id_valid & ~id_ex_bubble.
//  Hazard (combinational):
//   - id_valid & ((id_rs_used & hit(id_rs)) | (id_rt_used & hit(id_rt))).
//   - hit(r) = (sb_ex.v & sb_ex.reg==r) | (sb_mem.v & sb_mem.reg==r) | (~WB_BYPASS & sb_wb.v & sb_wb.reg==r).
//  FSM states RUN, DRAIN, HALTED. Priority within a cycle: redirect > hazard > halt.
//  RUN:
//   - ex_redirect: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1; stay in RUN.
//   - hazard: pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt+=1, saturating at all-ones.
//   - id_valid & id_halt, no hazard: HALT issues into ID/EX; pc_en=0, if_id_en=1, if_id_flush=1.
//     Go to DRAIN with drain counter = DRAIN_CYCLES-1.
//   - otherwise: 1,1,0,0.
//  DRAIN:
//   - pc_en=0, if_id_en=1, if_id_flush=1, id_ex_bubble=1.
//   - Counter decrements; at 0 go to HALTED.
//   - ex_redirect while in DRAIN comes from an older branch: HALT was wrong-path.
//     Abort to RUN with redirect outputs (1,1,1,1); the counter is cleared.
//  HALTED:
//   - pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=1, halted=1.
//   - Sticky until rst is asserted.
//  Reset mid-DRAIN or mid-stall returns to the reset state immediately; nothing is retained.
//  Latency: a hazard clears when the writer leaves MEM (WB_BYPASS=1), so at most 2 stall cycles.
//  stall_cnt does not count redirect or drain cycles.
// TESTING
//  1. Reset, then id_valid=1 with no register use for 5 cycles -> pc_en=1, if_id_en=1, bubble=0 each cycle; stall_cnt=0.
//  2. Writes r3, then next instruction reads rs=3 -> 2 stall cycles (pc_en=0, bubble=1), issues on the 3rd; stall_cnt=2.
//  3. Same as 2 with WB_BYPASS=0 -> 3 stall cycles; stall_cnt=3.
//  4. Hazard and ex_redirect in the same cycle -> if_id_flush=1, bubble=1, pc_en=1; stall_cnt unchanged.
//  5. HALT in ID, no hazard -> DRAIN for 4 cycles, then halted=1 and pc_en=0 held for 10 more cycles.
//  6. HALT issues, ex_redirect in the 1st DRAIN cycle -> back to RUN, halted stays 0; rst low mid-DRAIN -> reset outputs at once.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and sequencing control for the IF/ID and ID/EX
//               registers of the 16-bit 5-stage core. Tracks in-flight
//               destination registers (EX/MEM/WB), stalls on RAW hazards,
//               flushes on EX redirects and drains the pipe on HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_BITS     = 3,
    parameter int WB_BYPASS    = 1,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_id_valid,
    input  logic                i_id_rs_used,
    input  logic [REG_BITS-1:0] i_id_rs,
    input  logic                i_id_rt_used,
    input  logic [REG_BITS-1:0] i_id_rt,
    input  logic                i_id_reg_wrt,
    input  logic [REG_BITS-1:0] i_id_write_reg,
    input  logic                i_id_halt,
    input  logic                i_ex_redirect,
    output logic                o_pc_en,
    output logic                o_if_id_en,
    output logic                o_if_id_flush,
    output logic                o_id_ex_bubble,
    output logic                o_halted,
    output logic [CNT_W-1:0]    o_stall_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [DCW-1:0]   c_DRAIN_INIT = DCW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic             c_WB_CHECK   = (WB_BYPASS == 0);

    logic [1:0]          r_state;
    logic [DCW-1:0]      r_drain_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_sb_ex_v,  r_sb_mem_v,  r_sb_wb_v;
    logic [REG_BITS-1:0] r_sb_ex_reg, r_sb_mem_reg, r_sb_wb_reg;

    logic                w_hit_rs;
    logic                w_hit_rt;
    logic                w_hazard;
    logic                w_issue;
    logic                w_pc_en;
    logic                w_if_id_en;
    logic                w_flush;
    logic                w_bubble;
    logic                w_halted;
    logic                w_stall_inc;
    logic [1:0]          w_state_nxt;
    logic [DCW-1:0]      w_drain_nxt;

    // RAW hazard: a source register matches a valid in-flight destination.
    // The WB entry only matters when the regfile cannot forward its write.
    always_comb begin
        w_hit_rs = (r_sb_ex_v  && (r_sb_ex_reg  == i_id_rs)) ||
                   (r_sb_mem_v && (r_sb_mem_reg == i_id_rs)) ||
                   (c_WB_CHECK && r_sb_wb_v && (r_sb_wb_reg == i_id_rs));
        w_hit_rt = (r_sb_ex_v  && (r_sb_ex_reg  == i_id_rt)) ||
                   (r_sb_mem_v && (r_sb_mem_reg == i_id_rt)) ||
                   (c_WB_CHECK && r_sb_wb_v && (r_sb_wb_reg == i_id_rt));
        w_hazard = i_id_valid &&
                   ((i_id_rs_used && w_hit_rs) || (i_id_rt_used && w_hit_rt));
    end

    // Control outputs and next state; redirect beats hazard beats halt.
    always_comb begin
        w_pc_en     = 1'b1;
        w_if_id_en  = 1'b1;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_halted    = 1'b0;
        w_stall_inc = 1'b0;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            S_RUN: begin
                if (i_ex_redirect) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_hazard) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_bubble    = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (i_id_valid && i_id_halt) begin
                    // HALT itself moves into ID/EX; everything behind it is squashed.
                    w_pc_en     = 1'b0;
                    w_flush     = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = c_DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (i_ex_redirect) begin
                    // An older branch resolved: the HALT was on the wrong path.
                    w_flush     = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = S_RUN;
                    w_drain_nxt = '0;
                end else begin
                    w_pc_en  = 1'b0;
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_drain_cnt == '0) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 1'b1;
                    end
                end
            end
            S_HALTED: begin
                w_pc_en    = 1'b0;
                w_if_id_en = 1'b0;
                w_bubble   = 1'b1;
                w_halted   = 1'b1;
            end
            default: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_flush     = 1'b1;
                w_bubble    = 1'b1;
                w_state_nxt = S_RUN;
                w_drain_nxt = '0;
            end
        endcase
    end

    assign w_issue = i_id_valid && !w_bubble;

    // While reset is asserted the pipe is frozen with a NOP in IF/ID and a bubble in ID/EX.
    assign o_pc_en        = rst_n && w_pc_en;
    assign o_if_id_en     = rst_n && w_if_id_en;
    assign o_if_id_flush  = !rst_n || w_flush;
    assign o_id_ex_bubble = !rst_n || w_bubble;
    assign o_halted       = rst_n && w_halted;
    assign o_stall_cnt    = r_stall_cnt;

    // FSM state and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Destination scoreboard; advances every cycle, independent of stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_ex_v    <= 1'b0;
            r_sb_mem_v   <= 1'b0;
            r_sb_wb_v    <= 1'b0;
            r_sb_ex_reg  <= '0;
            r_sb_mem_reg <= '0;
            r_sb_wb_reg  <= '0;
        end else begin
            r_sb_ex_v    <= w_issue && i_id_reg_wrt;
            r_sb_ex_reg  <= i_id_write_reg;
            r_sb_mem_v   <= r_sb_ex_v;
            r_sb_mem_reg <= r_sb_ex_reg;
            r_sb_wb_v    <= r_sb_mem_v;
            r_sb_wb_reg  <= r_sb_mem_reg;
        end
    end

    // Saturating count of RAW-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Two instances run in
//               lockstep: default parameters, and WB_BYPASS=0 with a 2-bit
//               stall counter. A cycle-level reference model predicts outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic       id_reg_wrt = 1'b0, id_halt = 1'b0, ex_redirect = 1'b0;
    logic [2:0] id_rs = '0, id_rt = '0, id_write_reg = '0;

    logic        pc0, ifen0, fl0, bub0, hlt0;
    logic        pc1, ifen1, fl1, bub1, hlt1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model state: destinations issued 1..3 cycles ago (-1 = none).
    int hist  [2][4];
    int mode  [2];
    int dleft [2];
    int scnt  [2];
    int cmax  [2] = '{65535, 3};
    int byp   [2] = '{1, 0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs_used(id_rs_used), .i_id_rs(id_rs),
        .i_id_rt_used(id_rt_used), .i_id_rt(id_rt), .i_id_reg_wrt(id_reg_wrt),
        .i_id_write_reg(id_write_reg), .i_id_halt(id_halt), .i_ex_redirect(ex_redirect),
        .o_pc_en(pc0), .o_if_id_en(ifen0), .o_if_id_flush(fl0),
        .o_id_ex_bubble(bub0), .o_halted(hlt0), .o_stall_cnt(cnt0)
    );

    pipe_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs_used(id_rs_used), .i_id_rs(id_rs),
        .i_id_rt_used(id_rt_used), .i_id_rt(id_rt), .i_id_reg_wrt(id_reg_wrt),
        .i_id_write_reg(id_write_reg), .i_id_halt(id_halt), .i_ex_redirect(ex_redirect),
        .o_pc_en(pc1), .o_if_id_en(ifen1), .o_if_id_flush(fl1),
        .o_id_ex_bubble(bub1), .o_halted(hlt1), .o_stall_cnt(cnt1)
    );

    logic [4:0] w_ctl0, w_ctl1;
    assign w_ctl0 = {pc0, ifen0, fl0, bub0, hlt0};
    assign w_ctl1 = {pc1, ifen1, fl1, bub1, hlt1};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit busy(input int m, input int r);
        return (hist[m][1] == r) || (hist[m][2] == r) || (byp[m] == 0 && hist[m][3] == r);
    endfunction

    function automatic logic [4:0] ctl_of(input int m);
        return (m == 0) ? w_ctl0 : w_ctl1;
    endfunction

    function automatic logic [31:0] cnt_of(input int m);
        return (m == 0) ? 32'(cnt0) : 32'(cnt1);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 4; k++) hist[m][k] = -1;
            mode[m]  = M_RUN;
            dleft[m] = 0;
            scnt[m]  = 0;
        end
    endtask

    // Assert reset at a falling edge; outputs must change without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {id_valid, id_rs_used, id_rt_used, id_reg_wrt, id_halt, ex_redirect} = '0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("rst_ctl_u%0d", m), 32'(ctl_of(m)), 32'b00110);
            check_val($sformatf("rst_cnt_u%0d", m), cnt_of(m), 0);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic step(input bit v, input bit rsu, input int rs, input bit rtu, input int rt,
                        input bit wr, input int wd, input bit hlt, input bit rd);
        @(negedge clk);
        rst_n        = 1'b1;
        id_valid     = v;
        id_rs_used   = rsu;
        id_rs        = 3'(rs);
        id_rt_used   = rtu;
        id_rt        = 3'(rt);
        id_reg_wrt   = wr;
        id_write_reg = 3'(wd);
        id_halt      = hlt;
        ex_redirect  = rd;
        #1;
        for (int m = 0; m < 2; m++) begin
            bit         hz;
            logic [4:0] e;
            hz = v && ((rsu && busy(m, rs)) || (rtu && busy(m, rt)));
            if (mode[m] == M_HALT)       e = 5'b00011;
            else if (mode[m] == M_DRAIN) e = rd ? 5'b11110 : 5'b01110;
            else if (rd)                 e = 5'b11110;
            else if (hz)                 e = 5'b00010;
            else if (v && hlt)           e = 5'b01100;
            else                         e = 5'b11000;
            check_val($sformatf("c%0d_ctl_u%0d", cyc, m), 32'(ctl_of(m)), 32'(e));
            check_val($sformatf("c%0d_cnt_u%0d", cyc, m), cnt_of(m), 32'(scnt[m]));
            hist[m][3] = hist[m][2];
            hist[m][2] = hist[m][1];
            hist[m][1] = (v && !e[1] && wr) ? wd : -1;
            if (mode[m] == M_RUN) begin
                if (!rd && hz) begin
                    if (scnt[m] < cmax[m]) scnt[m]++;
                end else if (!rd && v && hlt) begin
                    mode[m]  = M_DRAIN;
                    dleft[m] = DRAIN_CYCLES;
                end
            end else if (mode[m] == M_DRAIN) begin
                if (rd) begin
                    mode[m] = M_RUN;
                end else begin
                    dleft[m]--;
                    if (dleft[m] == 0) mode[m] = M_HALT;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Observe registered outputs just after the edge that closes the last step.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int halted_run;
        model_reset();

        // Plain issue with no register use.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        check_val("t1_cnt", 32'(cnt0), 0);

        // Write r3 then read r3: 2 stalls with bypass, 3 without.
        do_reset();
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        after_edge();
        check_val("t2_cnt_bypass", 32'(cnt0), 2);
        check_val("t3_cnt_nobypass", 32'(cnt1), 3);

        // Hazard coinciding with a redirect: redirect wins, no stall counted.
        do_reset();
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 0, 0, 1, 3, 0, 0, 0, 1);
        check_val("t4_ctl", 32'(w_ctl0), 32'b11110);
        after_edge();
        check_val("t4_cnt", 32'(cnt0), 0);

        // HALT: four drain cycles, then halted held.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(DRAIN_CYCLES + 10);
        after_edge();
        check_val("t5_halted", 32'(hlt0), 1);
        check_val("t5_pc_en", 32'(pc0), 0);

        // Wrong-path HALT aborted by a redirect, then reset mid-drain.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(6);
        after_edge();
        check_val("t6_not_halted", 32'(hlt0), 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        do_reset();
        idle(2);

        // Randomized traffic with occasional resets.
        halted_run = 0;
        for (int i = 0; i < 1500; i++) begin
            if ((mode[0] == M_HALT && mode[1] == M_HALT) || $urandom_range(0, 149) == 0)
                halted_run++;
            if (halted_run > 3) begin
                do_reset();
                halted_run = 0;
            end
            step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
